// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for timer_ctrl: register offsets, CTRL bit layout, MODE codes, FSM states.
package timer_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_BITS     = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

endpackage

// File: rtl/timer_ctrl_be.sv
// Byte-lane write merge: each lane of the result takes the new data where its enable is set.
// Purely combinational; compiled only when TIMER_BE_EN is defined.
module be_merge
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   oldDat,
  input  logic [WIDTH-1:0]   newDat,
  input  logic [WIDTH/8-1:0] be,
  output logic [WIDTH-1:0]   mergedDat
);

  always_comb begin
    mergedDat = oldDat;
    for (int i = 0; i < WIDTH / 8; i++) begin
      if (be[i]) mergedDat[i*8 +: 8] = newDat[i*8 +: 8];
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer with CTRL/PRESET/COUNT registers; reads are combinational, writes land on the next edge.
// No backpressure on the bus; TIMER_BE_EN enables byte-lane writes to CTRL/PRESET.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:2]       Addr,
  input  logic             WE,
  input  logic [3:0]       BE,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             IRQ
);

  ctrl_t            ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic             irqFlag;
  state_t           state;

  logic [WIDTH-1:0] ctrlWord;
  logic [WIDTH-1:0] wrWord;
  logic             wrAny;
  logic             wrCtrl;
  logic             wrPreset;
  ctrl_t            wrCtrlVal;
  logic             stopRun;

  assign ctrlWord = {{(WIDTH-CTRL_BITS){1'b0}}, ctrl};

`ifdef TIMER_BE_EN
  logic [WIDTH-1:0] oldWord;

  assign oldWord = (Addr == ADDR_CTRL) ? ctrlWord : preset;

  be_merge #(.WIDTH(WIDTH)) uMerge (
    .oldDat   (oldWord),
    .newDat   (Din),
    .be       (BE),
    .mergedDat(wrWord)
  );

  // An all-zero BE is not a write at all, so it must not clear irqFlag either.
  assign wrAny = WE && (BE != 4'b0000);
`else
  logic unusedBe;

  assign unusedBe = ^BE;
  assign wrWord   = Din;
  assign wrAny    = WE;
`endif

  assign wrCtrl   = wrAny && (Addr == ADDR_CTRL);
  assign wrPreset = wrAny && (Addr == ADDR_PRESET);

  assign wrCtrlVal.en   = wrWord[CTRL_EN_BIT];
  assign wrCtrlVal.mode = wrWord[CTRL_MODE_LSB +: 2];
  assign wrCtrlVal.im   = wrWord[CTRL_IM_BIT];

  // Software disabling the timer overrides whatever the FSM would do this cycle.
  assign stopRun = wrCtrl && !wrCtrlVal.en;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
      preset    <= '0;
      count     <= '0;
      irqFlag   <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      if (wrPreset) preset <= wrWord;

      if (wrCtrl) begin
        ctrl    <= wrCtrlVal;
        irqFlag <= 1'b0;
      end else if (state == ST_INT) begin
        irqFlag <= 1'b1;
        if (ctrl.mode != MODE_AUTO) ctrl.en <= 1'b0;
      end else if (irqFlag && ctrl.mode == MODE_AUTO) begin
        irqFlag <= 1'b0;
      end

      if (stopRun) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (ctrl.en) state <= ST_LOAD;
          ST_LOAD: begin
            count <= preset;
            state <= ST_CNT;
          end
          ST_CNT: begin
            if (!ctrl.en) begin
              state <= ST_IDLE;
            end else if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end
          ST_INT: state <= (ctrl.mode == MODE_AUTO) ? ST_LOAD : ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = ctrlWord;
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = ctrl.im & irqFlag;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expectations are queued as stimulus is driven and checked after each edge.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:2]   Addr;
  logic         WE;
  logic [3:0]   BE;
  logic [W-1:0] Din;
  logic [W-1:0] Dout;
  logic         IRQ;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .BE   (BE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 = Dout at addr, 1 = IRQ, 2 = FSM state
    logic [1:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total   = 0;
  int   passCnt = 0;
  int   failCnt = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    Addr = a;
    Din  = d;
    BE   = b;
    WE   = 1'b1;
    cycle();
  endtask

  task automatic push(input string tag, input int kind, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.addr = a;
    e.exp  = v;
    sbq.push_back(e);
  endtask

  task automatic expDout(input string tag, input logic [1:0] a, input logic [31:0] v);
    push(tag, 0, a, v);
  endtask

  task automatic expIrq(input string tag, input logic v);
    push(tag, 1, 2'd0, {31'b0, v});
  endtask

  task automatic expState(input string tag, input state_t s);
    push(tag, 2, 2'd0, {30'b0, s});
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0: begin
          Addr = e.addr;
          #1;
          obs = Dout;
        end
        1:       obs = {31'b0, IRQ};
        default: obs = {30'b0, dut.state};
      endcase
      total++;
      assert (obs === e.exp) passCnt++;
      else begin
        failCnt++;
        $error("FAIL %s: observed 0x%h expected 0x%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    logic [31:0] ec;
    int          m;

    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    BE    = 4'hF;
    Din   = '0;

    // Reset: registers read zero, and a PRESET write while in reset is dropped.
    cycle();
    cycle();
    wr(ADDR_PRESET, 32'd5, 4'hF);
    for (int a = 0; a < 4; a++) expDout($sformatf("rst_dout_a%0d", a), 2'(a), 32'd0);
    expIrq("rst_irq", 1'b0);
    drain();
    reset = 1'b0;
    cycle();
    expDout("rst_preset_ignored", ADDR_PRESET, 32'd0);
    expState("rst_state", ST_IDLE);
    drain();

    // One-shot, PRESET=3: COUNT 3,2,1,0 from edge 2, IRQ from edge 6 and held.
    wr(ADDR_PRESET, 32'd3, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    expIrq("os_irq_k0", 1'b0);
    drain();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      ec = (k < 2) ? 32'd0 : (k <= 5) ? 32'(5 - k) : 32'd0;
      expDout($sformatf("os_count_k%0d", k), ADDR_COUNT, ec);
      expIrq($sformatf("os_irq_k%0d", k), k >= 6);
      if (k == 6) expDout("os_ctrl_en_cleared", ADDR_CTRL, 32'h8);
      drain();
    end
    wr(ADDR_CTRL, 32'h0, 4'hF);
    expIrq("os_irq_cleared_by_ctrl", 1'b0);
    drain();

    // Auto-reload, PRESET=2: pulses every 4 cycles; PRESET=5 written mid-count stretches the next period to 7.
    wr(ADDR_PRESET, 32'd2, 4'hF);
    wr(ADDR_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 25; k++) begin
      if (k == 15) begin
        Addr = ADDR_PRESET;
        Din  = 32'd5;
        BE   = 4'hF;
        WE   = 1'b1;
      end
      cycle();
      if (k < 2) begin
        ec = 32'd0;
      end else if (k <= 17) begin
        m  = (k - 2) % 4;
        ec = (m <= 2) ? 32'(2 - m) : 32'd0;
      end else if (k <= 23) begin
        ec = 32'(23 - k);
      end else if (k == 24) begin
        ec = 32'd0;
      end else begin
        ec = 32'd5;
      end
      expDout($sformatf("ar_count_k%0d", k), ADDR_COUNT, ec);
      expIrq($sformatf("ar_irq_k%0d", k), (k == 5) || (k == 9) || (k == 13) || (k == 17) || (k == 24));
      drain();
    end
    wr(ADDR_CTRL, 32'h0, 4'hF);
    expIrq("ar_stop_irq", 1'b0);
    expState("ar_stop_state", ST_IDLE);
    drain();

    // Masked interrupt: the one-shot completes but IRQ never rises.
    wr(ADDR_PRESET, 32'd1, 4'hF);
    wr(ADDR_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      expIrq($sformatf("mask_irq_k%0d", k), 1'b0);
      drain();
    end
    expDout("mask_ctrl_en_cleared", ADDR_CTRL, 32'h0);
    expDout("mask_count_zero", ADDR_COUNT, 32'd0);
    drain();

    // Disable mid-count at COUNT=0x10: COUNT freezes and the FSM idles.
    wr(ADDR_PRESET, 32'h20, 4'hF);
    wr(ADDR_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 18; k++) cycle();
    expDout("frz_count_before", ADDR_COUNT, 32'h10);
    drain();
    wr(ADDR_CTRL, 32'h0, 4'hF);
    expDout("frz_count_at_stop", ADDR_COUNT, 32'h10);
    expState("frz_state_idle", ST_IDLE);
    drain();
    for (int k = 1; k <= 3; k++) cycle();
    expDout("frz_count_held", ADDR_COUNT, 32'h10);
    expState("frz_state_held", ST_IDLE);
    drain();

    // Writes to COUNT and to the reserved word are ignored.
    wr(ADDR_COUNT, 32'hFFFF, 4'hF);
    expDout("cnt_write_ignored", ADDR_COUNT, 32'h10);
    drain();
    wr(2'd3, 32'hFFFF, 4'hF);
    expDout("addr3_reads_zero", 2'd3, 32'd0);
    expDout("addr3_count_intact", ADDR_COUNT, 32'h10);
    drain();

    // PRESET=0 and PRESET=1 both raise IRQ 4 edges after the enabling write.
    for (int p = 0; p <= 1; p++) begin
      wr(ADDR_PRESET, 32'(p), 4'hF);
      wr(ADDR_CTRL, 32'h9, 4'hF);
      for (int k = 1; k <= 6; k++) begin
        cycle();
        expIrq($sformatf("p%0d_irq_k%0d", p, k), k >= 4);
        drain();
      end
      wr(ADDR_CTRL, 32'h0, 4'hF);
    end

    // CTRL write in the one-shot INT cycle: written EN survives and a fresh run follows.
    wr(ADDR_PRESET, 32'd1, 4'hF);
    wr(ADDR_CTRL, 32'h9, 4'hF);
    for (int k = 1; k <= 3; k++) cycle();
    expState("col_in_int", ST_INT);
    drain();
    wr(ADDR_CTRL, 32'h9, 4'hF);
    expDout("col_ctrl_written", ADDR_CTRL, 32'h9);
    expIrq("col_irq_cleared", 1'b0);
    drain();
    for (int k = 5; k <= 8; k++) begin
      cycle();
      expIrq($sformatf("col_irq_k%0d", k), k == 8);
      drain();
    end
    expDout("col_ctrl_after_rerun", ADDR_CTRL, 32'h8);
    drain();
    wr(ADDR_CTRL, 32'h0, 4'hF);

    // Byte-lane writes to PRESET.
    wr(ADDR_PRESET, 32'h11223344, 4'hF);
    wr(ADDR_PRESET, 32'hAABBCCDD, 4'b0101);
`ifdef TIMER_BE_EN
    expDout("be_partial", ADDR_PRESET, 32'h11BB33DD);
`else
    expDout("be_partial", ADDR_PRESET, 32'hAABBCCDD);
`endif
    drain();
    wr(ADDR_PRESET, 32'h55667788, 4'b0000);
`ifdef TIMER_BE_EN
    expDout("be_zero", ADDR_PRESET, 32'h11BB33DD);
`else
    expDout("be_zero", ADDR_PRESET, 32'h55667788);
`endif
    drain();

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
